// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the Sram front-end: macro geometry, burst field width and FSM encoding.
package sram_ctrl_pkg;

   localparam int unsigned SRAM_ADDR_W = 4;
   localparam int unsigned SRAM_DATA_W = 32;
   localparam int unsigned REQ_LEN_W   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

endpackage

// File: rtl/sram.sv
// 16x32 single-port Sram macro model: one-cycle registered read, zero when not reading, cleared on Rst.
module sram
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = SRAM_ADDR_W,
   parameter int unsigned DATA_W = SRAM_DATA_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              En,
   input  logic              RW,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] Data_In,
   output logic [DATA_W-1:0] Data_Out
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] data_out_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         data_out_q <= '0;
      end else begin
         if (En && RW) begin
            mem_q[Addr] <= Data_In;
         end
         data_out_q <= (En && !RW) ? mem_q[Addr] : '0;
      end
   end

   assign Data_Out = data_out_q;

endmodule

// File: rtl/sram_ctrl.sv
// Burst request front-end for the Sram macro: sequences one access per cycle with address wrap
// and turns the one-cycle read latency into a Rd_Valid/Rd_Data stream.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = SRAM_ADDR_W,
   parameter int unsigned DATA_W = SRAM_DATA_W,
   parameter int unsigned LEN_W  = REQ_LEN_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Req_RW,
   input  logic [ADDR_W-1:0] Req_Addr,
   input  logic [LEN_W-1:0]  Req_Len,
   input  logic              Wr_Valid,
   output logic              Wr_Ready,
   input  logic [DATA_W-1:0] Wr_Data,
   output logic              Rd_Valid,
   output logic [DATA_W-1:0] Rd_Data,
   output logic              Busy,
   output logic              Mem_En,
   output logic              Mem_RW,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_Wdata,
   input  logic [DATA_W-1:0] Mem_Rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  beats_left_q, beats_left_d;
   logic              rd_pend_q, rd_pend_d;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         beats_left_q <= '0;
         rd_pend_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         beats_left_q <= beats_left_d;
         rd_pend_q    <= rd_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      beats_left_d = beats_left_q;
      rd_pend_d    = 1'b0;
      Req_Ready    = 1'b0;
      Wr_Ready     = 1'b0;
      Mem_En       = 1'b0;
      Mem_RW       = 1'b0;
      Mem_Addr     = cur_addr_q;
      Mem_Wdata    = Wr_Data;
      Rd_Valid     = rd_pend_q;
      Rd_Data      = Mem_Rdata;
      Busy         = (state_q != IDLE) || rd_pend_q;

      case (state_q)
         IDLE: begin
            Req_Ready = 1'b1;
            if (Req_Valid) begin
               cur_addr_d   = Req_Addr;
               beats_left_d = Req_Len;
               state_d      = Req_RW ? WRITE : READ;
            end
         end
         WRITE: begin
            Wr_Ready = 1'b1;
            Mem_En   = Wr_Valid;
            Mem_RW   = 1'b1;
            if (Wr_Valid) begin
               cur_addr_d   = cur_addr_q + ADDR_W'(1);
               beats_left_d = beats_left_q - LEN_W'(1);
               if (beats_left_q == '0) begin
                  state_d = IDLE;
               end
            end
         end
         READ: begin
            Mem_En       = 1'b1;
            rd_pend_d    = 1'b1;
            cur_addr_d   = cur_addr_q + ADDR_W'(1);
            beats_left_d = beats_left_q - LEN_W'(1);
            if (beats_left_q == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset silences every handshake and Sram strobe in the same cycle.
      if (Rst) begin
         Req_Ready = 1'b0;
         Wr_Ready  = 1'b0;
         Mem_En    = 1'b0;
         Mem_RW    = 1'b0;
         Rd_Valid  = 1'b0;
         Busy      = 1'b0;
         rd_pend_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl + sram: transaction-level memory model with expectation queues, plus literal checks.
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int unsigned AW = SRAM_ADDR_W;
   localparam int unsigned DW = SRAM_DATA_W;
   localparam int unsigned LW = REQ_LEN_W;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Req_Valid, Req_Ready, Req_RW;
   logic [AW-1:0] Req_Addr;
   logic [LW-1:0] Req_Len;
   logic          Wr_Valid, Wr_Ready;
   logic [DW-1:0] Wr_Data;
   logic          Rd_Valid;
   logic [DW-1:0] Rd_Data;
   logic          Busy, Mem_En, Mem_RW;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_Wdata, Mem_Rdata;

   always #5 Clk = ~Clk;

   sram_ctrl u_ctrl (
      .Clk(Clk), .Rst(Rst),
      .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_RW(Req_RW),
      .Req_Addr(Req_Addr), .Req_Len(Req_Len),
      .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
      .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data), .Busy(Busy),
      .Mem_En(Mem_En), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr),
      .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata)
   );

   sram u_sram (
      .Clk(Clk), .Rst(Rst), .En(Mem_En), .RW(Mem_RW), .Addr(Mem_Addr),
      .Data_In(Mem_Wdata), .Data_Out(Mem_Rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   logic [DW-1:0] model_mem [16];
   logic [DW-1:0] wbuf [4];
   logic [AW-1:0] exp_wr_addr [$];
   logic [DW-1:0] exp_wr_data [$];
   logic [AW-1:0] exp_rd_addr [$];
   logic [DW-1:0] exp_rd_data [$];
   logic [DW-1:0] cap_data [$];
   int            cap_cyc [$];
   bit            prev_issue = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Every-cycle checker against the expectation queues filled by the stimulus tasks.
   always @(negedge Clk) begin
      if (Rst) begin
         chk("rst_outputs_low", DW'({Req_Ready, Wr_Ready, Mem_En, Rd_Valid, Busy}), '0);
         exp_wr_addr.delete();
         exp_wr_data.delete();
         exp_rd_addr.delete();
         exp_rd_data.delete();
         prev_issue = 1'b0;
      end else begin
         chk("rd_valid_one_cycle_after_issue", DW'(Rd_Valid), DW'(prev_issue));
         if (Rd_Valid) begin
            if (exp_rd_data.size() == 0) fail_now("unexpected_rd_valid");
            else chk("rd_data", Rd_Data, exp_rd_data.pop_front());
            cap_data.push_back(Rd_Data);
            cap_cyc.push_back(cyc);
         end
         prev_issue = Mem_En && !Mem_RW;
         if (Mem_En && Mem_RW) begin
            if (exp_wr_addr.size() == 0) fail_now("unexpected_sram_write");
            else begin
               chk("wr_addr", DW'(Mem_Addr), DW'(exp_wr_addr.pop_front()));
               chk("wr_data", Mem_Wdata, exp_wr_data.pop_front());
            end
         end
         if (Mem_En && !Mem_RW) begin
            if (exp_rd_addr.size() == 0) fail_now("unexpected_sram_read");
            else chk("rd_addr", DW'(Mem_Addr), DW'(exp_rd_addr.pop_front()));
         end
         if (Mem_En || Rd_Valid || Wr_Ready) chk("busy_when_active", DW'(Busy), DW'(1));
         if (Req_Ready) chk("idle_no_access", DW'({Mem_En, Wr_Ready}), '0);
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_read_exp(input logic [AW-1:0] a, input logic [LW-1:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         logic [AW-1:0] ad;
         ad = AW'(int'(a) + i);
         exp_rd_addr.push_back(ad);
         exp_rd_data.push_back(model_mem[ad]);
      end
   endtask

   task automatic handshake(input bit rw, input logic [AW-1:0] a, input logic [LW-1:0] len,
                            output int acc);
      int k;
      Req_Valid = 1'b1;
      Req_RW    = rw;
      Req_Addr  = a;
      Req_Len   = len;
      acc       = -1;
      for (k = 0; k < 20; k++) begin
         @(negedge Clk);
         if (Req_Ready) break;
      end
      if (k == 20) fail_now("req_accept_timeout");
      else acc = cyc;
      tick();
      Req_Valid = 1'b0;
   endtask

   task automatic write_beats(input logic [AW-1:0] a, input logic [LW-1:0] len,
                              input int gap_after, input int gap);
      for (int i = 0; i <= int'(len); i++) begin
         logic [AW-1:0] ad;
         int k;
         ad = AW'(int'(a) + i);
         exp_wr_addr.push_back(ad);
         exp_wr_data.push_back(wbuf[i]);
         model_mem[ad] = wbuf[i];
         Wr_Valid = 1'b1;
         Wr_Data  = wbuf[i];
         for (k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Wr_Ready) break;
         end
         if (k == 20) fail_now("wr_beat_timeout");
         tick();
         Wr_Valid = 1'b0;
         if (i == gap_after) begin
            repeat (gap) begin
               @(negedge Clk);
               chk("wr_ready_through_gap", DW'(Wr_Ready), DW'(1));
               tick();
            end
         end
      end
   endtask

   task automatic send_read(input logic [AW-1:0] a, input logic [LW-1:0] len, output int acc);
      push_read_exp(a, len);
      handshake(1'b0, a, len, acc);
      repeat (int'(len) + 3) tick();
   endtask

   int acc_r, acc_w, busy_low;
   logic rdv_at_acc;
   int mism;

   initial begin
      Rst = 1'b1; Req_Valid = 1'b0; Req_RW = 1'b0; Req_Addr = '0; Req_Len = '0;
      Wr_Valid = 1'b0; Wr_Data = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      repeat (3) tick();
      Rst = 1'b0;
      @(negedge Clk);
      chk("reset_req_ready", DW'(Req_Ready), DW'(1));
      chk("reset_busy", DW'(Busy), DW'(0));
      tick();

      // Single write then read
      wbuf[0] = 32'hDEADBEEF;
      handshake(1'b1, AW'(3), LW'(0), acc_w);
      write_beats(AW'(3), LW'(0), -1, 0);
      tick();
      cap_data.delete(); cap_cyc.delete();
      send_read(AW'(3), LW'(0), acc_r);
      chk("single_rd_count", DW'(cap_data.size()), DW'(1));
      if (cap_data.size() == 1) begin
         chk("single_rd_value", cap_data[0], 32'hDEADBEEF);
         chk("single_rd_latency", DW'(cap_cyc[0] - acc_r), DW'(2));
      end

      // Wrapping burst with a 2-cycle write gap after beat 2
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      handshake(1'b1, AW'(14), LW'(3), acc_w);
      write_beats(AW'(14), LW'(3), 1, 2);
      tick();
      chk("wrap_mem14", u_sram.mem_q[14], 32'h11);
      chk("wrap_mem15", u_sram.mem_q[15], 32'h22);
      chk("wrap_mem0",  u_sram.mem_q[0],  32'h33);
      chk("wrap_mem1",  u_sram.mem_q[1],  32'h44);
      cap_data.delete(); cap_cyc.delete();
      send_read(AW'(14), LW'(3), acc_r);
      chk("wrap_rd_count", DW'(cap_data.size()), DW'(4));
      if (cap_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("wrap_rd_value", cap_data[i], DW'(32'h11 * (i + 1)));
            chk("wrap_rd_consecutive", DW'(cap_cyc[i] - acc_r), DW'(2 + i));
         end
      end

      // Back-to-back: read Len=1 followed by a write request held valid
      cap_data.delete(); cap_cyc.delete();
      push_read_exp(AW'(14), LW'(1));
      handshake(1'b0, AW'(14), LW'(1), acc_r);
      Req_Valid = 1'b1; Req_RW = 1'b1; Req_Addr = AW'(5); Req_Len = LW'(0);
      busy_low = 0; acc_w = -1; rdv_at_acc = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clk);
         if (!Busy) busy_low++;
         if (Req_Ready) begin
            acc_w = cyc;
            rdv_at_acc = Rd_Valid;
            break;
         end
      end
      if (acc_w < 0) fail_now("b2b_accept_timeout");
      tick();
      Req_Valid = 1'b0;
      chk("b2b_accept_cycle", DW'(acc_w - acc_r), DW'(3));
      chk("b2b_rd_valid_at_accept", DW'(rdv_at_acc), DW'(1));
      wbuf[0] = 32'h0000_00AB;
      @(negedge Clk);
      if (!Busy) busy_low++;
      tick();
      write_beats(AW'(5), LW'(0), -1, 0);
      chk("b2b_busy_continuous", DW'(busy_low), DW'(0));
      chk("b2b_rd_count", DW'(cap_data.size()), DW'(2));
      tick();

      // Reset during beat 2 of a Len=3 read
      push_read_exp(AW'(0), LW'(3));
      handshake(1'b0, AW'(0), LW'(3), acc_r);
      tick();
      tick();
      Rst = 1'b1;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      @(negedge Clk);
      chk("midrst_rd_valid", DW'(Rd_Valid), DW'(0));
      chk("midrst_mem_en", DW'(Mem_En), DW'(0));
      chk("midrst_req_ready", DW'(Req_Ready), DW'(0));
      tick();
      Rst = 1'b0;
      @(negedge Clk);
      chk("postrst_req_ready", DW'(Req_Ready), DW'(1));
      tick();
      cap_data.delete(); cap_cyc.delete();
      send_read(AW'(0), LW'(0), acc_r);
      chk("postrst_rd_count", DW'(cap_data.size()), DW'(1));
      if (cap_data.size() == 1) chk("postrst_rd_zero", cap_data[0], 32'h0);

      // Idle hygiene: Wr_Valid pulsed with no write request
      wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
      handshake(1'b1, AW'(7), LW'(1), acc_w);
      write_beats(AW'(7), LW'(1), -1, 0);
      tick();
      Wr_Valid = 1'b1;
      Wr_Data  = 32'hBAD0BAD0;
      @(negedge Clk);
      chk("idle_wr_mem_en", DW'(Mem_En), DW'(0));
      chk("idle_wr_ready", DW'(Wr_Ready), DW'(0));
      tick();
      Wr_Valid = 1'b0;
      tick();
      mism = 0;
      for (int i = 0; i < 16; i++) if (u_sram.mem_q[i] !== model_mem[i]) mism++;
      chk("idle_mem_unchanged", DW'(mism), DW'(0));
      chk("idle_mem8_literal", u_sram.mem_q[8], 32'hCAFE0002);

      repeat (3) tick();
      chk("no_leftover_expectations",
          DW'(exp_wr_addr.size() + exp_rd_addr.size() + exp_rd_data.size()), DW'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "simulation did not finish");
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Request/response front-end that sits directly upstream of the 16x32 Sram macro and drives its En/RW/Addr/Data_In pins. It accepts single or burst (1-4 beat) read/write requests over a valid/ready handshake. It sequences one Sram access per cycle with address auto-increment and wrap. It re-times the one-cycle Sram read latency into a Rd_Valid/Rd_Data response stream.

Parameters:
ADDR_W, 4, Sram address width (16 words)
DATA_W, 32, data word width
LEN_W, 2, burst-length field width; beats = Req_Len+1 (1..4)

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high; also wired to the Sram Rst
Req_Valid  in  1  request present
Req_Ready  out  1  controller accepts a request this cycle
Req_RW  in  1  1=write, 0=read
Req_Addr  in  ADDR_W  start word address
Req_Len  in  LEN_W  beats minus one
Wr_Valid  in  1  write beat data present
Wr_Ready  out  1  controller consumes a write beat this cycle
Wr_Data  in  DATA_W  write beat data
Rd_Valid  out  1  read beat returned (no backpressure)
Rd_Data  out  DATA_W  read beat data
Busy  out  1  burst in progress or read beat in flight
Mem_En  out  1  to Sram En
Mem_RW  out  1  to Sram RW
Mem_Addr  out  ADDR_W  to Sram Addr
Mem_Wdata  out  DATA_W  to Sram Data_In
Mem_Rdata  in  DATA_W  from Sram Data_Out

Behaviour:
- States: IDLE, WRITE, READ. Registers: state, cur_addr (ADDR_W), beats_left (LEN_W), rd_pend (1).
- Reset (Rst=1 at posedge): state=IDLE, cur_addr=0, beats_left=0, rd_pend=0. While Rst=1, all outputs are combinationally forced low: Req_Ready=0, Wr_Ready=0, Mem_En=0, Rd_Valid=0, Busy=0. Reset mid-burst abandons the burst with no further Sram access. The Sram clears itself on the same Rst.
- IDLE: Req_Ready=1, Mem_En=0.
  - On Req_Valid&Req_Ready: cur_addr<=Req_Addr, beats_left<=Req_Len.
  - Next state is WRITE if Req_RW=1, else READ.
  - No Sram access occurs in the accept cycle.
- WRITE: Wr_Ready=1; Mem_En=Wr_Valid, Mem_RW=1, Mem_Addr=cur_addr, Mem_Wdata=Wr_Data (all combinational).
  - Wr_Valid=0: stall; state and counters hold.
  - Wr_Valid=1: cur_addr<=cur_addr+1 (mod 16, 15->0 wrap); beats_left decrements.
  - On the beat with beats_left==0: go to IDLE.
- READ: Mem_En=1, Mem_RW=0, Mem_Addr=cur_addr every cycle; never stalls.
  - cur_addr increments with wrap; beats_left decrements.
  - On beats_left==0: go to IDLE.
- Read latency: rd_pend<=1 in any cycle a read is issued, else 0.
  - Rd_Valid=rd_pend; Rd_Data=Mem_Rdata (combinational pass-through).
  - Rd_Data is valid exactly one cycle after issue. Consumer must accept every beat.
  - Rd_Data is undefined when Rd_Valid=0 (Sram returns 0).
- Back-to-back: the last read beat's Rd_Valid coincides with the first IDLE cycle, and a new request may be accepted in that cycle.
  - Throughput: 1 beat/cycle within a burst; 1 idle accept cycle between bursts.
- Busy=(state!=IDLE)|rd_pend.
- Wr_Valid is ignored outside WRITE (Wr_Ready=0). Req_Valid is ignored outside IDLE.
- Mem_Wdata=Wr_Data in all states; it is don't-care when no write is issued.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, WRITE=2'd1, READ=2'd2) and the ADDR_W/DATA_W defaults shared with the Sram.
- No sub-module is needed: a single FSM plus counters.
- The bench instantiates sram_ctrl together with the Sram as the DUT pair.

Test Plan:
- Single write then read:
  - Step 1: write request Addr=3, Len=0, Wr_Data=0xDEADBEEF.
  - Step 2: read request Addr=3, Len=0.
  - Required: Rd_Valid for exactly one cycle, the cycle after the read issue, with Rd_Data=0xDEADBEEF.
- Wrapping burst:
  - Step 1: write Addr=14, Len=3, data 0x11,0x22,0x33,0x44 (Wr_Valid gapped 2 cycles after beat 2).
  - Required: Sram words 14,15,0,1 hold 0x11,0x22,0x33,0x44; Wr_Ready stays high through the gap.
  - Step 2: read burst Addr=14, Len=3.
  - Required: 4 consecutive Rd_Valid beats returning 0x11,0x22,0x33,0x44.
- Back-to-back:
  - Stimulus: read Len=1, then a write request held valid.
  - Required: the write is accepted in the same cycle as the last Rd_Valid; Busy is high continuously.
- Reset mid-burst:
  - Stimulus: assert Rst during beat 2 of a Len=3 read.
  - Required: the next cycle shows Rd_Valid=0, Mem_En=0, Req_Ready=0; after Rst deasserts, Req_Ready=1, and a read of Addr=0 returns 0.
- Idle hygiene:
  - Stimulus: Wr_Valid=1 pulsed in IDLE.
  - Required: no Sram write occurs (Mem_En=0); Sram contents are unchanged.
